// File: rtl/undo_buf.sv
// undo_buf: LIFO ring of 2^DEPTH_LOG2 entries holding overwritten values for reverse execution.
// Optional peek-by-offset read path is built only when UNDO_PEEK_EN is defined.
module undo_buf #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_valid,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop_req,
  output logic                  pop_valid,
  output logic [WIDTH-1:0]      pop_data,
  input  logic [DEPTH_LOG2-1:0] peek_off,
  output logic [WIDTH-1:0]      peek_data,
  output logic                  peek_ok,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  err_underflow,
  output logic                  err_overflow
);

  localparam int                  D         = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_MAX = D[DEPTH_LOG2:0];

  typedef enum logic [1:0] {OP_IDLE, OP_PUSH, OP_POP, OP_SWAP} op_e;

  logic [WIDTH-1:0]      r_mem [D];
  logic [DEPTH_LOG2-1:0] r_sp;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_pop_valid;
  logic [WIDTH-1:0]      r_pop_data;
  logic                  r_err_underflow;
  logic                  r_err_overflow;

  op_e                   w_op;
  logic [DEPTH_LOG2-1:0] w_top_idx;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_mem_we;
  logic [DEPTH_LOG2-1:0] w_mem_idx;

  assign w_top_idx = r_sp - DEPTH_LOG2'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == COUNT_MAX);

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_op      = OP_IDLE;
    w_mem_we  = 1'b0;
    w_mem_idx = r_sp;
    unique case ({push_valid, pop_req})
      2'b10:   w_op = OP_PUSH;
      2'b01:   w_op = OP_POP;
      2'b11:   w_op = OP_SWAP;
      default: w_op = OP_IDLE;
    endcase
    // A swap replaces the top in place; a swap on an empty stack is a pure bypass.
    if (w_op == OP_PUSH) begin
      w_mem_we = 1'b1;
    end else if (w_op == OP_SWAP && !w_empty) begin
      w_mem_we  = 1'b1;
      w_mem_idx = w_top_idx;
    end
  end

  // NOTE: storage has no reset; only the pointer and occupancy define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp            <= '0;
      r_count         <= '0;
      r_pop_valid     <= 1'b0;
      r_pop_data      <= '0;
      r_err_underflow <= 1'b0;
      r_err_overflow  <= 1'b0;
    end else begin
      r_pop_valid <= pop_req;
      unique case (w_op)
        OP_PUSH: begin
          // When full, sp already points at the oldest entry, which gets overwritten.
          r_sp <= r_sp + DEPTH_LOG2'(1);
          if (w_full) r_err_overflow <= 1'b1;
          else        r_count        <= r_count + (DEPTH_LOG2+1)'(1);
        end
        OP_POP: begin
          if (w_empty) begin
            r_pop_data      <= '0;
            r_err_underflow <= 1'b1;
          end else begin
            r_pop_data <= r_mem[w_top_idx];
            r_sp       <= w_top_idx;
            r_count    <= r_count - (DEPTH_LOG2+1)'(1);
          end
        end
        OP_SWAP: r_pop_data <= w_empty ? push_data : r_mem[w_top_idx];
        default: ;
      endcase
    end
  end

`ifdef UNDO_PEEK_EN
  logic [DEPTH_LOG2-1:0] w_peek_idx;
  assign w_peek_idx = w_top_idx - peek_off;
  assign peek_data  = r_mem[w_peek_idx];
  assign peek_ok    = ({1'b0, peek_off} < r_count);
`else
  logic w_unused_peek_off;
  assign w_unused_peek_off = ^peek_off;
  assign peek_data         = '0;
  assign peek_ok           = 1'b0;
`endif

  assign pop_valid     = r_pop_valid;
  assign pop_data      = r_pop_data;
  assign count         = r_count;
  assign empty         = w_empty;
  assign full          = w_full;
  assign err_underflow = r_err_underflow;
  assign err_overflow  = r_err_overflow;

endmodule

// File: tb/tb_undo_buf.sv
// Directed bench for undo_buf: vector table for push/pop/swap/peek, plus overflow and async-reset sequences.
// Peek expectations follow whether UNDO_PEEK_EN is defined for the build.
module tb_undo_buf;

`ifdef UNDO_PEEK_EN
  localparam bit PEEK = 1'b1;
`else
  localparam bit PEEK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        push_valid;
  logic [15:0] push_data;
  logic        pop_req;
  logic        pop_valid;
  logic [15:0] pop_data;
  logic [3:0]  peek_off;
  logic [15:0] peek_data;
  logic        peek_ok;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic        err_underflow;
  logic        err_overflow;

  int n_vec = 0;
  int n_err = 0;

  undo_buf #(.WIDTH(16), .DEPTH_LOG2(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .push_valid    (push_valid),
    .push_data     (push_data),
    .pop_req       (pop_req),
    .pop_valid     (pop_valid),
    .pop_data      (pop_data),
    .peek_off      (peek_off),
    .peek_data     (peek_data),
    .peek_ok       (peek_ok),
    .count         (count),
    .empty         (empty),
    .full          (full),
    .err_underflow (err_underflow),
    .err_overflow  (err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [15:0] pd;
    logic        pr;
    logic [3:0]  off;
    logic        e_pv;
    logic [15:0] e_pd;
    logic [4:0]  e_cnt;
    logic        chk_ok;
    logic        e_ok;
    logic        chk_pk;
    logic [15:0] e_pk;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic pv, input logic [15:0] pd, input logic pr, input logic [3:0] off,
                     input logic e_pv, input logic [15:0] e_pd, input logic [4:0] e_cnt,
                     input logic chk_ok, input logic e_ok, input logic chk_pk, input logic [15:0] e_pk);
    vec_t v;
    v.pv = pv; v.pd = pd; v.pr = pr; v.off = off;
    v.e_pv = e_pv; v.e_pd = e_pd; v.e_cnt = e_cnt;
    v.chk_ok = chk_ok; v.e_ok = e_ok; v.chk_pk = chk_pk; v.e_pk = e_pk;
    vq.push_back(v);
  endtask

  task automatic check_state(input string tag, input logic [4:0] e_cnt, input logic e_uf, input logic e_of);
    check({tag, " count"}, 32'(count), 32'(e_cnt));
    check({tag, " empty"}, 32'(empty), 32'(e_cnt == 5'd0));
    check({tag, " full"}, 32'(full), 32'(e_cnt == 5'd16));
    check({tag, " err_underflow"}, 32'(err_underflow), 32'(e_uf));
    check({tag, " err_overflow"}, 32'(err_overflow), 32'(e_of));
  endtask

  initial begin
    reset = 1'b1; push_valid = 1'b0; push_data = '0; pop_req = 1'b0; peek_off = '0;

    //  pv  data      pr off   e_pv e_pd      cnt  chk_ok e_ok  chk_pk e_pk
    add(1, 16'h1111, 0, 4'd0, 0, 16'h0000, 5'd1, 0, 0, 0, 16'h0000);
    add(1, 16'h2222, 0, 4'd0, 0, 16'h0000, 5'd2, 0, 0, 0, 16'h0000);
    add(1, 16'h3333, 0, 4'd0, 0, 16'h0000, 5'd3, 0, 0, 0, 16'h0000);
    add(0, 16'h0000, 1, 4'd0, 1, 16'h3333, 5'd2, 0, 0, 0, 16'h0000);
    add(0, 16'h0000, 1, 4'd0, 1, 16'h2222, 5'd1, 0, 0, 0, 16'h0000);
    add(0, 16'h0000, 1, 4'd0, 1, 16'h1111, 5'd0, 0, 0, 0, 16'h0000);
    add(1, 16'h1234, 0, 4'd0, 0, 16'h0000, 5'd1, 0, 0, 0, 16'h0000);
    add(1, 16'hBEEF, 0, 4'd0, 0, 16'h0000, 5'd2, 0, 0, 0, 16'h0000);
    add(1, 16'hCAFE, 1, 4'd0, 1, 16'hBEEF, 5'd2, 0, 0, 0, 16'h0000);
    add(0, 16'h0000, 1, 4'd0, 1, 16'hCAFE, 5'd1, 0, 0, 0, 16'h0000);
    add(0, 16'h0000, 1, 4'd0, 1, 16'h1234, 5'd0, 0, 0, 0, 16'h0000);
    add(1, 16'h00A5, 1, 4'd0, 1, 16'h00A5, 5'd0, 0, 0, 0, 16'h0000);
    add(0, 16'h0000, 0, 4'd0, 0, 16'h0000, 5'd0, 1, 0, 0, 16'h0000);
    add(1, 16'h0010, 0, 4'd0, 0, 16'h0000, 5'd1, 0, 0, 0, 16'h0000);
    add(1, 16'h0020, 0, 4'd0, 0, 16'h0000, 5'd2, 0, 0, 0, 16'h0000);
    add(1, 16'h0030, 0, 4'd0, 0, 16'h0000, 5'd3, 0, 0, 0, 16'h0000);
    add(0, 16'h0000, 0, 4'd0, 0, 16'h0000, 5'd3, 1, PEEK, 1, PEEK ? 16'h0030 : 16'h0000);
    add(0, 16'h0000, 0, 4'd1, 0, 16'h0000, 5'd3, 1, PEEK, 1, PEEK ? 16'h0020 : 16'h0000);
    add(0, 16'h0000, 0, 4'd2, 0, 16'h0000, 5'd3, 1, PEEK, 1, PEEK ? 16'h0010 : 16'h0000);
    add(0, 16'h0000, 0, 4'd3, 0, 16'h0000, 5'd3, 1, 0, !PEEK, 16'h0000);
    add(0, 16'h0000, 1, 4'd0, 1, 16'h0030, 5'd2, 0, 0, 0, 16'h0000);
    add(0, 16'h0000, 1, 4'd0, 1, 16'h0020, 5'd1, 0, 0, 0, 16'h0000);
    add(0, 16'h0000, 1, 4'd0, 1, 16'h0010, 5'd0, 0, 0, 0, 16'h0000);

    repeat (2) step();
    check("reset pop_valid", 32'(pop_valid), 32'd0);
    check("reset pop_data", 32'(pop_data), 32'd0);
    check_state("reset", 5'd0, 1'b0, 1'b0);
    reset = 1'b0;

    foreach (vq[i]) begin
      push_valid = vq[i].pv; push_data = vq[i].pd; pop_req = vq[i].pr; peek_off = vq[i].off;
      step();
      check($sformatf("vec%0d pop_valid", i), 32'(pop_valid), 32'(vq[i].e_pv));
      if (vq[i].e_pv) check($sformatf("vec%0d pop_data", i), 32'(pop_data), 32'(vq[i].e_pd));
      check_state($sformatf("vec%0d", i), vq[i].e_cnt, 1'b0, 1'b0);
      if (vq[i].chk_ok) check($sformatf("vec%0d peek_ok", i), 32'(peek_ok), 32'(vq[i].e_ok));
      if (vq[i].chk_pk) check($sformatf("vec%0d peek_data", i), 32'(peek_data), 32'(vq[i].e_pk));
    end
    push_valid = 1'b0; pop_req = 1'b0; peek_off = '0;

    // Overflow: 17 pushes into 16 entries, then drain past empty.
    for (int i = 0; i < 17; i++) begin
      push_valid = 1'b1; push_data = 16'(i);
      step();
      check_state($sformatf("ovf push%0d", i), (i < 16) ? 5'(i + 1) : 5'd16, 1'b0, i == 16);
    end
    push_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      pop_req = 1'b1;
      step();
      check($sformatf("ovf pop%0d pop_valid", k), 32'(pop_valid), 32'd1);
      check($sformatf("ovf pop%0d pop_data", k), 32'(pop_data), 32'(16 - k));
      check_state($sformatf("ovf pop%0d", k), 5'(15 - k), 1'b0, 1'b1);
    end
    step();
    check("underflow pop_valid", 32'(pop_valid), 32'd1);
    check("underflow pop_data", 32'(pop_data), 32'd0);
    check_state("underflow", 5'd0, 1'b1, 1'b1);
    pop_req = 1'b0;
    step();
    check("idle pop_valid", 32'(pop_valid), 32'd0);

    // Async reset between edges with count=5 and a pop result in flight.
    for (int i = 0; i < 6; i++) begin
      push_valid = 1'b1; push_data = 16'(16'h0100 + i);
      step();
    end
    push_valid = 1'b0; pop_req = 1'b1;
    step();
    pop_req = 1'b0;
    check("pre-reset pop_valid", 32'(pop_valid), 32'd1);
    check("pre-reset pop_data", 32'(pop_data), 32'h0105);
    check_state("pre-reset", 5'd5, 1'b1, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async reset pop_valid", 32'(pop_valid), 32'd0);
    check("async reset pop_data", 32'(pop_data), 32'd0);
    check_state("async reset", 5'd0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    pop_req = 1'b1;
    step();
    pop_req = 1'b0;
    check("post-reset pop_valid", 32'(pop_valid), 32'd1);
    check("post-reset pop_data", 32'(pop_data), 32'd0);
    check_state("post-reset", 5'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
